// File: rtl/uop_sequencer_pkg.sv
// Shared types and field layout for the microcode uop buffer and its sequencer.
// Each 72-bit bundle holds two 36-bit slots; slot0 sits in the upper half.
package uop_pkg;

    localparam int UOP_BUF_SIZE           = 128;
    localparam int UOP_BUF_WIDTH          = 72;
    localparam int INSN_WIDTH             = 32;
    localparam int MAX_PREDICT_DEPTH_BITS = 2;

    localparam int ADDR_W     = $clog2(UOP_BUF_SIZE);
    localparam int PC_W       = ADDR_W + 1;
    localparam int SLOT_WIDTH = UOP_BUF_WIDTH / 2;

    localparam int SLOT0_LSB = SLOT_WIDTH;
    localparam int SLOT1_LSB = 0;
    localparam int INSN_LSB  = 4;
    localparam int TAG_LSB   = 2;
    localparam int VALID_BIT = 1;
    localparam int SPEC_BIT  = 0;

    typedef logic [ADDR_W-1:0] uop_addr_t;

    typedef struct packed {
        logic [INSN_WIDTH-1:0]             insn;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag;
        logic                              valid;
        logic                              spec;
    } uop_slot_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE0,
        ISSUE1,
        HALT
    } seq_state_e;

    function automatic uop_slot_t slot_decode(input logic [SLOT_WIDTH-1:0] raw);
        uop_slot_t s;
        s.insn  = raw[INSN_LSB +: INSN_WIDTH];
        s.tag   = raw[TAG_LSB +: MAX_PREDICT_DEPTH_BITS];
        s.valid = raw[VALID_BIT];
        s.spec  = raw[SPEC_BIT];
        return s;
    endfunction

    // Explicit wrap so the buffer size need not stay a power of two.
    function automatic uop_addr_t addr_inc(input uop_addr_t a);
        return (a == uop_addr_t'(UOP_BUF_SIZE - 1)) ? '0 : a + uop_addr_t'(1);
    endfunction

endpackage

// File: rtl/uop_sequencer_if.sv
// Issue channel from the sequencer to decode: one instruction slot per
// valid/ready handshake.
interface uop_issue_if;
    import uop_pkg::*;

    logic                              out_valid;
    logic                              out_ready;
    logic [INSN_WIDTH-1:0]             out_insn;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] out_tag;
    logic                              out_spec;
    logic [PC_W-1:0]                   out_pc;

    modport master (
        output out_valid,
        output out_insn,
        output out_tag,
        output out_spec,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_insn,
        input  out_tag,
        input  out_spec,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/uop_sequencer_unpack.sv
// Splits a uop bundle into its two decoded slots; index 0 is slot0 (upper half).
// Kept standalone so the microcode unit can reuse the same unpacking.
module uop_slot_unpack
    import uop_pkg::*;
(
    input  logic [UOP_BUF_WIDTH-1:0] i_bundle,
    output uop_slot_t [1:0]          o_slots
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        localparam int LSB = (gi == 0) ? SLOT0_LSB : SLOT1_LSB;
        assign o_slots[gi] = slot_decode(i_bundle[LSB +: SLOT_WIDTH]);
    end

endmodule

// File: rtl/uop_sequencer.sv
// Walks the uop buffer from a start address, fetching one bundle at a time and
// issuing its valid slots to decode; stops on an all-invalid bundle.
module uop_sequencer
    import uop_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  uop_addr_t                start_addr,
    output uop_addr_t                uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0] uop,
    uop_issue_if.master              issue,
    input  logic                     redirect_valid,
    input  uop_addr_t                redirect_addr,
    output logic                     busy,
    output logic                     halted
);

    seq_state_e               r_state;
    uop_addr_t                r_uop_addr;
    uop_addr_t                r_bundle_addr;
    logic [UOP_BUF_WIDTH-1:0] r_bundle;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_halted;

    seq_state_e               w_state_next;
    uop_addr_t                w_uop_addr_next;
    logic                     w_fetch_latch;
    logic                     w_in_slot0_valid;
    logic                     w_in_slot1_valid;
    uop_slot_t [1:0]          w_reg_slots;
    uop_slot_t                w_out_slot;
    logic                     w_unused_slot0_valid;

    assign w_in_slot0_valid = uop[SLOT0_LSB + VALID_BIT];
    assign w_in_slot1_valid = uop[SLOT1_LSB + VALID_BIT];

    uop_slot_unpack u_unpack (
        .i_bundle (r_bundle),
        .o_slots  (w_reg_slots)
    );

    always_comb begin
        w_state_next    = r_state;
        w_uop_addr_next = r_uop_addr;
        w_fetch_latch   = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_state_next    = FETCH;
                    w_uop_addr_next = start_addr;
                end
            end
            FETCH: begin
                w_fetch_latch = 1'b1;
                if (w_in_slot0_valid) begin
                    w_state_next    = ISSUE0;
                    w_uop_addr_next = addr_inc(r_uop_addr);
                end else if (w_in_slot1_valid) begin
                    w_state_next    = ISSUE1;
                    w_uop_addr_next = addr_inc(r_uop_addr);
                end else begin
                    // Park on the empty bundle so its address is visible while halted.
                    w_state_next = HALT;
                end
            end
            ISSUE0: begin
                if (issue.out_ready) begin
                    w_state_next = w_reg_slots[1].valid ? ISSUE1 : FETCH;
                end
            end
            ISSUE1: begin
                if (issue.out_ready) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A redirect coinciding with a handshake still lets that slot count;
        // only the rest of the bundle is abandoned.
        if (redirect_valid && (r_state != IDLE)) begin
            w_state_next    = FETCH;
            w_uop_addr_next = redirect_addr;
            w_fetch_latch   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_uop_addr    <= '0;
            r_bundle      <= '0;
            r_bundle_addr <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_uop_addr <= w_uop_addr_next;
            if (w_fetch_latch) begin
                r_bundle      <= uop;
                r_bundle_addr <= r_uop_addr;
            end
            r_out_valid <= (w_state_next == ISSUE0) || (w_state_next == ISSUE1);
            r_busy      <= (w_state_next != IDLE);
            r_halted    <= (w_state_next == HALT);
        end
    end

    // Outside ISSUE1 the slot0 fields are presented, giving deterministic idle values.
    assign w_out_slot           = (r_state == ISSUE1) ? w_reg_slots[1] : w_reg_slots[0];
    assign w_unused_slot0_valid = w_reg_slots[0].valid;

    assign issue.out_valid = r_out_valid;
    assign issue.out_insn  = w_out_slot.insn;
    assign issue.out_tag   = w_out_slot.tag;
    assign issue.out_spec  = w_out_slot.spec;
    assign issue.out_pc    = {r_bundle_addr, (r_state == ISSUE1)};

    assign uop_addr = r_uop_addr;
    assign busy     = r_busy;
    assign halted   = r_halted;

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: a table of single-bundle vectors plus
// hand-written sequences, with issued slots checked against a scoreboard queue.
module tb_uop_sequencer;
    import uop_pkg::*;

    typedef struct {
        logic [PC_W-1:0]                   pc;
        logic [INSN_WIDTH-1:0]             insn;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag;
        logic                              spec;
    } exp_t;

    typedef struct {
        uop_addr_t                addr;
        logic [UOP_BUF_WIDTH-1:0] bundle;
        int                       n_exp;
        exp_t                     exp0;
        exp_t                     exp1;
        uop_addr_t                halt_addr;
        int                       lat;
    } vec_t;

    logic                     clk;
    logic                     reset;
    logic                     start;
    uop_addr_t                start_addr;
    uop_addr_t                uop_addr;
    logic [UOP_BUF_WIDTH-1:0] uop;
    logic                     redirect_valid;
    uop_addr_t                redirect_addr;
    logic                     busy;
    logic                     halted;

    logic [UOP_BUF_WIDTH-1:0] mem [UOP_BUF_SIZE];
    exp_t                     sb [$];
    vec_t                     vecs [6];
    int                       n_tests;
    int                       n_fail;

    uop_issue_if u_if ();

    uop_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .uop_addr       (uop_addr),
        .uop            (uop),
        .issue          (u_if),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .busy           (busy),
        .halted         (halted)
    );

    assign uop = mem[uop_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    function automatic logic [SLOT_WIDTH-1:0] mk_slot(input logic [INSN_WIDTH-1:0] insn,
                                                      input logic [1:0] tag,
                                                      input logic valid, input logic spec);
        return {insn, tag, valid, spec};
    endfunction

    function automatic logic [INSN_WIDTH-1:0] pat_insn(input int pc);
        return 32'hA500_0000 ^ (32'(pc) * 32'h0001_0003);
    endfunction

    function automatic logic [SLOT_WIDTH-1:0] pat_slot(input int pc);
        return mk_slot(pat_insn(pc), 2'(pc), 1'b1, 1'(pc));
    endfunction

    task automatic push_pat(input int pc);
        exp_t e;
        e.pc   = PC_W'(pc);
        e.insn = pat_insn(pc);
        e.tag  = 2'(pc);
        e.spec = 1'(pc);
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < UOP_BUF_SIZE; i++) mem[i] = '0;
    endtask

    // Starts at sa, then runs cycle by cycle until HALT, popping the scoreboard on
    // every handshake. Optional ready stall at stall_pc and redirect on the
    // handshake of redir_pc. Entered and left just after a falling edge.
    task automatic run_seq(input uop_addr_t sa, input bit redir_at_start, input uop_addr_t ra_start,
                           input int stall_pc, input int stall_cycles,
                           input int redir_pc, input uop_addr_t redir_addr,
                           input uop_addr_t exp_halt, output int first_valid);
        int                    stall_left = 0;
        bit                    stalled    = 0;
        bit                    redirected = 0;
        bit                    first      = 0;
        bit                    done       = 0;
        logic [PC_W-1:0]       held_pc    = '0;
        logic [INSN_WIDTH-1:0] held_insn  = '0;
        exp_t                  e;
        first_valid = -1;
        start       = 1'b1;
        start_addr  = sa;
        if (redir_at_start) begin
            redirect_valid = 1'b1;
            redirect_addr  = ra_start;
        end
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge clk);
            start          = 1'b0;
            redirect_valid = 1'b0;
            u_if.out_ready = 1'b1;
            if (halted) begin
                done = 1;
            end else begin
                if (u_if.out_valid && first_valid < 0) first_valid = cyc;
                if (u_if.out_valid && !stalled && int'(u_if.out_pc) == stall_pc) begin
                    stalled    = 1;
                    stall_left = stall_cycles;
                    first      = 1;
                    held_pc    = u_if.out_pc;
                    held_insn  = u_if.out_insn;
                end
                if (stall_left > 0) begin
                    if (!first) begin
                        chk("stall_valid", 64'(u_if.out_valid), 64'(1));
                        chk("stall_pc", 64'(u_if.out_pc), 64'(held_pc));
                        chk("stall_insn", 64'(u_if.out_insn), 64'(held_insn));
                    end
                    first          = 0;
                    u_if.out_ready = 1'b0;
                    stall_left--;
                end else if (u_if.out_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue", u_if.out_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("issue_pc", 64'(u_if.out_pc), 64'(e.pc));
                        chk("issue_insn", 64'(u_if.out_insn), 64'(e.insn));
                        chk("issue_tag", 64'(u_if.out_tag), 64'(e.tag));
                        chk("issue_spec", 64'(u_if.out_spec), 64'(e.spec));
                    end
                    if (!redirected && int'(u_if.out_pc) == redir_pc) begin
                        redirected     = 1;
                        redirect_valid = 1'b1;
                        redirect_addr  = redir_addr;
                    end
                end
            end
        end
        chk("halt_reached", 64'(halted), 64'(1));
        chk("halt_uop_addr", 64'(uop_addr), 64'(exp_halt));
        chk("halt_out_valid", 64'(u_if.out_valid), 64'(0));
        chk("sb_drained", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    initial begin
        int         lat;
        logic [31:0] ia, ib, ic, id;
        bit         hit;
        n_tests = 0;
        n_fail  = 0;
        ia = 32'hDEAD_BEEF;
        ib = 32'h0000_0001;
        ic = 32'h8000_0000;
        id = 32'h7FFF_FFFF;

        vecs[0] = '{7'd10, {mk_slot(ia, 2'd1, 1'b1, 1'b0), mk_slot(ib, 2'd3, 1'b1, 1'b1)}, 2,
                    '{8'd20, ia, 2'd1, 1'b0}, '{8'd21, ib, 2'd3, 1'b1}, 7'd11, 2};
        vecs[1] = '{7'd10, {mk_slot(ia, 2'd1, 1'b0, 1'b0), mk_slot(ib, 2'd3, 1'b1, 1'b1)}, 1,
                    '{8'd21, ib, 2'd3, 1'b1}, '{8'd0, 32'd0, 2'd0, 1'b0}, 7'd11, 2};
        vecs[2] = '{7'd10, {mk_slot(ia, 2'd2, 1'b1, 1'b1), mk_slot(ib, 2'd0, 1'b0, 1'b0)}, 1,
                    '{8'd20, ia, 2'd2, 1'b1}, '{8'd0, 32'd0, 2'd0, 1'b0}, 7'd11, 2};
        vecs[3] = '{7'd33, {UOP_BUF_WIDTH{1'b0}}, 0,
                    '{8'd0, 32'd0, 2'd0, 1'b0}, '{8'd0, 32'd0, 2'd0, 1'b0}, 7'd33, -1};
        vecs[4] = '{7'd127, {mk_slot(ic, 2'd0, 1'b1, 1'b0), mk_slot(id, 2'd1, 1'b1, 1'b0)}, 2,
                    '{8'd254, ic, 2'd0, 1'b0}, '{8'd255, id, 2'd1, 1'b0}, 7'd0, 2};
        vecs[5] = '{7'd64, {mk_slot(ia, 2'd3, 1'b0, 1'b1), mk_slot(ib, 2'd0, 1'b0, 1'b1)}, 0,
                    '{8'd0, 32'd0, 2'd0, 1'b0}, '{8'd0, 32'd0, 2'd0, 1'b0}, 7'd64, -1};

        reset          = 1'b0;
        start          = 1'b0;
        start_addr     = '0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        u_if.out_ready = 1'b1;
        clear_mem();

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(u_if.out_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_halted", 64'(halted), 64'(0));
        chk("reset_uop_addr", 64'(uop_addr), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        redirect_valid = 1'b1;
        redirect_addr  = 7'd55;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("idle_redirect_busy", 64'(busy), 64'(0));
        chk("idle_redirect_addr", 64'(uop_addr), 64'(0));

        // Full run of 20 bundles; bundle 5 has only slot1; ready stalls on pc 6.
        for (int b = 0; b < 20; b++) begin
            mem[b] = {mk_slot(32'h0120_5021, 2'd2, (b != 5), 1'b1), mk_slot(32'h0120_5021, 2'd2, 1'b1, 1'b1)};
            for (int s = 0; s < 2; s++) begin
                if (!(b == 5 && s == 0)) sb.push_back('{PC_W'(2 * b + s), 32'h0120_5021, 2'd2, 1'b1});
            end
        end
        run_seq(7'd0, 1'b0, 7'd0, 6, 4, -1, 7'd0, 7'd20, lat);
        chk("start_latency", 64'(lat), 64'(2));
        chk("halt_busy", 64'(busy), 64'(1));

        // Redirect on the slot0 handshake of bundle 2 drops pc 5.
        clear_mem();
        for (int b = 0; b < 4; b++) mem[b] = {pat_slot(2 * b), pat_slot(2 * b + 1)};
        for (int b = 100; b < 102; b++) mem[b] = {pat_slot(2 * b), pat_slot(2 * b + 1)};
        for (int pc = 0; pc <= 4; pc++) push_pat(pc);
        for (int pc = 200; pc <= 203; pc++) push_pat(pc);
        run_seq(7'd0, 1'b0, 7'd0, -1, 0, 4, 7'd100, 7'd102, lat);

        // Address wrap from the last bundle.
        clear_mem();
        mem[127] = {pat_slot(254), pat_slot(255)};
        mem[0]   = {pat_slot(0), mk_slot(32'hFFFF_FFFF, 2'd3, 1'b0, 1'b1)};
        push_pat(254);
        push_pat(255);
        push_pat(0);
        run_seq(7'd127, 1'b0, 7'd0, -1, 0, -1, 7'd0, 7'd1, lat);

        // Redirect beats start while halted.
        clear_mem();
        mem[50]  = {pat_slot(100), pat_slot(101)};
        mem[100] = {pat_slot(200), mk_slot(32'h1234_5678, 2'd1, 1'b0, 1'b0)};
        push_pat(200);
        run_seq(7'd50, 1'b1, 7'd100, -1, 0, -1, 7'd0, 7'd101, lat);

        for (int i = 0; i < 6; i++) begin
            clear_mem();
            mem[vecs[i].addr] = vecs[i].bundle;
            if (vecs[i].n_exp >= 1) sb.push_back(vecs[i].exp0);
            if (vecs[i].n_exp >= 2) sb.push_back(vecs[i].exp1);
            run_seq(vecs[i].addr, 1'b0, 7'd0, -1, 0, -1, 7'd0, vecs[i].halt_addr, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Asynchronous reset while slot1 is being presented.
        clear_mem();
        for (int b = 0; b < 10; b++) mem[b] = {pat_slot(2 * b), pat_slot(2 * b + 1)};
        start      = 1'b1;
        start_addr = 7'd0;
        hit        = 0;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (u_if.out_valid && u_if.out_pc[0]) hit = 1;
        end
        chk("reached_issue1", 64'(hit), 64'(1));
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(u_if.out_valid), 64'(0));
        chk("midreset_uop_addr", 64'(uop_addr), 64'(0));
        chk("midreset_busy", 64'(busy), 64'(0));
        chk("midreset_halted", 64'(halted), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("postreset_busy", 64'(busy), 64'(0));
        chk("postreset_out_valid", 64'(u_if.out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Sequences the microcode unit's uop buffer.
- Drives the buffer read address and captures one 72-bit bundle per fetch.
- Unpacks the bundle into two instruction slots and issues them one per cycle to decode over a valid/ready handshake.
- Handles start, redirect (branch resolve) and halt on an empty bundle.

Parameters:
UOP_BUF_SIZE, 128, number of bundles in the uop buffer; address width is $clog2(UOP_BUF_SIZE)
UOP_BUF_WIDTH, 72, bundle width; two 36-bit slots
INSN_WIDTH, 32, instruction field width
MAX_PREDICT_DEPTH_BITS, 2, branch tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin sequencing at start_addr; honoured in IDLE or HALT only
start_addr  in  $clog2(UOP_BUF_SIZE)  first bundle address
uop_addr  out  $clog2(UOP_BUF_SIZE)  buffer read address, registered
uop  in  UOP_BUF_WIDTH  bundle at uop_addr, combinational read, same cycle
out_valid  out  1  slot presented to decode
out_ready  in  1  decode accepts slot
out_insn  out  INSN_WIDTH  instruction
out_tag  out  MAX_PREDICT_DEPTH_BITS  branch tag
out_spec  out  1  speculative flag
out_pc  out  $clog2(UOP_BUF_SIZE)+1  {bundle address, slot index}
redirect_valid  in  1  branch-resolve redirect
redirect_addr  in  $clog2(UOP_BUF_SIZE)  redirect target bundle
busy  out  1  state != IDLE
halted  out  1  state == HALT

Behaviour:
- Bundle layout, per slot, slot0 = [71:36], slot1 = [35:0]:
  - insn = [35:4] relative to the slot
  - tag = [3:2]
  - valid = [1]
  - spec = [0]
- Reset (reset==0, async): state IDLE; uop_addr=0; bundle reg=0; bundle_addr=0; out_valid=0; busy=0; halted=0.
- State machine:
  - IDLE: start -> uop_addr<=start_addr, go FETCH. redirect ignored.
  - FETCH:
    - Latch uop into bundle reg; bundle_addr<=uop_addr; uop_addr<=uop_addr+1, wrapping UOP_BUF_SIZE-1 -> 0.
    - Next state: slot0.valid -> ISSUE0; else slot1.valid -> ISSUE1; else HALT, with uop_addr left at the empty bundle's address (no increment).
    - out_valid=0.
  - ISSUE0: out_valid=1 with slot0 fields. On out_ready: slot1.valid -> ISSUE1, else FETCH.
  - ISSUE1: out_valid=1 with slot1 fields. On out_ready -> FETCH.
  - HALT: out_valid=0; halted=1. start -> uop_addr<=start_addr, go FETCH.
- Output stability: out_insn, out_tag, out_spec and out_pc are driven from the bundle reg and state, and stay stable while out_valid && !out_ready.
- Output values outside ISSUE states: don't-care, but must equal the bundle reg slot0 fields (deterministic).
- Latency: start to first out_valid = 2 cycles. A full bundle occupies 3 cycles: FETCH + 2 issues with ready held high.
- Redirect:
  - redirect_valid in any state except IDLE has highest priority: uop_addr<=redirect_addr, go FETCH, halted clears next cycle.
  - Redirect in the same cycle as an out_valid&&out_ready handshake: the slot counts as accepted. The pending slot1 is dropped.
  - Redirect and start in the same cycle in HALT: redirect wins.
- Reset asserted mid-issue: immediate return to the reset values above; no partial issue.

Decomposition:
- Package uop_pkg:
  - UOP_BUF_SIZE, UOP_BUF_WIDTH, INSN_WIDTH, MAX_PREDICT_DEPTH_BITS
  - slot field offsets
  - uop_slot_t struct {insn, tag, valid, spec}
  - seq_state_e enum {IDLE, FETCH, ISSUE0, ISSUE1, HALT}
- Sub-module uop_slot_unpack: combinational, bundle -> two uop_slot_t. Shared with microcode_unit.

Test Plan:
- Reset release; start=1, start_addr=0; all 20 bundles = insn 'h1205021, tag 2, valid 1, spec 1, both slots, ready tied 1 -> first out_valid 2 cycles after start; out_pc sequence 0,1,2,3,...; every out_insn='h1205021, out_tag=2, out_spec=1; bundle 20 all-zero -> halted=1, uop_addr=20.
- Bundle 5 slot0 invalid, slot1 valid -> only out_pc=11 issued from bundle 5; no cycle with out_valid for pc 10.
- out_ready low for 4 cycles during ISSUE0 of bundle 3 -> out_valid held; out_insn/out_pc=6 stable; resumes with pc 7.
- Redirect to addr 100 during ISSUE0 handshake of bundle 2 -> pc 4 accepted; pc 5 never issued; next out_pc=200.
- start_addr=127 -> out_pc 254, 255, then 0 (address wrap).
- reset pulsed low during ISSUE1 -> out_valid=0, uop_addr=0, busy=0 immediately; start required to resume.
